// File: rtl/fb_types.sv
// Shared types and framebuffer geometry for the framebuffer port arbiter.
package fb_types;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 19;

  typedef logic [2:0]           Color;
  typedef logic [FB_ADDR_W-1:0] FbAddr;

  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_GL, OWN_FILL} ArbOwner;
  typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DONE} FillState;

  function automatic logic addr_in_range(input FbAddr a);
    return a < FbAddr'(FB_PIXELS);
  endfunction
endpackage

// File: rtl/fb_port_arbiter_if.sv
// Scanout and game-logic request/response bundle for the framebuffer arbiter.
interface fb_port_arbiter_if;
  import fb_types::*;

  logic  vga_req;
  FbAddr vga_addr;
  logic  vga_valid;
  Color  vga_data;
  logic  vga_miss;

  logic  gl_req;
  logic  gl_we;
  FbAddr gl_addr;
  Color  gl_wdata;
  logic  gl_gnt;
  logic  gl_rvalid;
  Color  gl_rdata;

  modport master (
    output vga_req, vga_addr, gl_req, gl_we, gl_addr, gl_wdata,
    input  vga_valid, vga_data, vga_miss, gl_gnt, gl_rvalid, gl_rdata
  );

  modport slave (
    input  vga_req, vga_addr, gl_req, gl_we, gl_addr, gl_wdata,
    output vga_valid, vga_data, vga_miss, gl_gnt, gl_rvalid, gl_rdata
  );
endinterface

// File: rtl/fb_fill_engine.sv
// Full-screen fill engine: walks every pixel once, writing only on granted cycles.
//   state     | meaning
//   FILL_IDLE | waiting for start
//   FILL_RUN  | requesting RAM; addr advances on each grant
//   FILL_DONE | one-cycle done pulse, then back to idle
module fb_fill_engine
  import fb_types::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  start,
  input  Color  color,
  input  logic  gnt,
  output logic  req,
  output FbAddr addr,
  output Color  data,
  output logic  busy,
  output logic  done
);
  FillState state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FILL_IDLE;
      addr  <= '0;
      data  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        FILL_IDLE: begin
          if (start) begin
            state <= FILL_RUN;
            addr  <= '0;
            data  <= color;
            busy  <= 1'b1;
          end
        end
        FILL_RUN: begin
          if (gnt) begin
            if (addr == FbAddr'(FB_PIXELS - 1)) begin
              state <= FILL_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        FILL_DONE: begin
          state <= FILL_IDLE;
          done  <= 1'b0;
        end
        default: state <= FILL_IDLE;
      endcase
    end
  end

  assign req = (state == FILL_RUN);
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout first, starvation-guarded game logic,
// fill engine on leftover cycles.
module fb_port_arbiter
  import fb_types::*;
#(
  parameter int MAX_GL_WAIT = 8
) (
  input  logic  clock,
  input  logic  reset,
  fb_port_arbiter_if.slave bus,
  input  logic  fill_start,
  input  Color  fill_color,
  output logic  fill_busy,
  output logic  fill_done,
  output FbAddr ram_address,
  output logic  ram_we,
  output Color  ram_wdata,
  input  Color  ram_rdata
);
  localparam int WAIT_W = $clog2(MAX_GL_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_GL_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  ArbOwner owner;
  logic    fill_req;
  FbAddr   fill_addr;
  Color    fill_data;
  logic    gl_in_range;
  logic    gl_oor_q;

  assign gl_in_range = addr_in_range(bus.gl_addr);

  always_comb begin
    owner = OWN_NONE;
    if (bus.gl_req && wait_cnt == WAIT_MAX) owner = OWN_GL;
    else if (bus.vga_req)                   owner = OWN_VGA;
    else if (bus.gl_req)                    owner = OWN_GL;
    else if (fill_req)                      owner = OWN_FILL;
  end

  always_comb begin
    ram_address = '0;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    case (owner)
      OWN_VGA: ram_address = bus.vga_addr;
      OWN_GL: begin
        ram_address = bus.gl_addr;
        ram_we      = bus.gl_we && gl_in_range;
        ram_wdata   = bus.gl_wdata;
      end
      OWN_FILL: begin
        ram_address = fill_addr;
        ram_we      = 1'b1;
        ram_wdata   = fill_data;
      end
      default: ;
    endcase
  end

  assign bus.gl_gnt = (owner == OWN_GL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt      <= '0;
      bus.vga_valid <= 1'b0;
      bus.vga_miss  <= 1'b0;
      bus.gl_rvalid <= 1'b0;
      gl_oor_q      <= 1'b0;
    end else begin
      if (!bus.gl_req || bus.gl_gnt) wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      bus.vga_valid <= (owner == OWN_VGA);
      bus.vga_miss  <= bus.vga_req && (owner == OWN_GL);
      bus.gl_rvalid <= bus.gl_gnt && !bus.gl_we;
      gl_oor_q      <= bus.gl_gnt && !bus.gl_we && !gl_in_range;
    end
  end

  // Read data comes straight from the RAM's registered output, masked when not valid.
  assign bus.vga_data = bus.vga_valid ? ram_rdata : '0;
  assign bus.gl_rdata = (bus.gl_rvalid && !gl_oor_q) ? ram_rdata : '0;

  fb_fill_engine u_fill (
    .clock (clock),
    .reset (reset),
    .start (fill_start),
    .color (fill_color),
    .gnt   (owner == OWN_FILL),
    .req   (fill_req),
    .addr  (fill_addr),
    .data  (fill_data),
    .busy  (fill_busy),
    .done  (fill_done)
  );
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench: RAM model plus a priority/framebuffer reference model checked every cycle.
module tb_fb_port_arbiter;
  import fb_types::*;

  localparam int MAX_W = 8;

  logic  clock = 1'b0;
  logic  reset;
  logic  fill_start;
  Color  fill_color;
  logic  fill_busy, fill_done;
  FbAddr ram_address;
  logic  ram_we;
  Color  ram_wdata, ram_rdata;

  fb_port_arbiter_if bus ();

  fb_port_arbiter #(.MAX_GL_WAIT(MAX_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .fill_start  (fill_start),
    .fill_color  (fill_color),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .ram_address (ram_address),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clock = ~clock;

  // RAM with partial decode: out-of-range addresses alias into the array
  Color mem [FB_PIXELS] = '{default: 3'd0};
  always @(posedge clock) begin
    if (ram_we) mem[int'(ram_address) % FB_PIXELS] <= ram_wdata;
    ram_rdata <= mem[int'(ram_address) % FB_PIXELS];
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endfunction

  // Reference model state
  Color shadow [FB_PIXELS] = '{default: 3'd0};
  int   m_wait, m_ptr;
  bit   m_busy, m_done;
  Color m_col;
  bit   e_vga_valid, e_vga_miss, e_gl_rvalid;
  Color e_vga_data, e_gl_rdata;
  bit   model_gnt;

  function automatic int sh_rd(input int a);
    return (a < FB_PIXELS) ? int'(shadow[a]) : 0;
  endfunction

  always @(negedge clock) begin : model_chk
    bit gl_win, vga_win, fill_win;
    int ga, va, ea, ew, ed;
    if (reset) begin
      m_wait = 0; m_ptr = 0; m_busy = 0; m_done = 0; m_col = '0;
      e_vga_valid = 0; e_vga_miss = 0; e_gl_rvalid = 0;
      e_vga_data = '0; e_gl_rdata = '0; model_gnt = 0;
    end else begin
      ga = int'(bus.gl_addr);
      va = int'(bus.vga_addr);
      gl_win   = bus.gl_req && (m_wait >= MAX_W || !bus.vga_req);
      vga_win  = bus.vga_req && !gl_win;
      fill_win = !bus.vga_req && !bus.gl_req && m_busy;
      ea = 0; ew = 0; ed = 0;
      if (gl_win) begin
        ea = ga; ew = int'(bus.gl_we && ga < FB_PIXELS); ed = int'(bus.gl_wdata);
      end else if (vga_win) begin
        ea = va;
      end else if (fill_win) begin
        ea = m_ptr; ew = 1; ed = int'(m_col);
      end
      chk("gl_gnt", bus.gl_gnt, gl_win);
      chk("ram_address", ram_address, ea);
      chk("ram_we", ram_we, ew);
      chk("ram_wdata", ram_wdata, ed);
      chk("vga_valid", bus.vga_valid, e_vga_valid);
      chk("vga_data", bus.vga_data, e_vga_data);
      chk("vga_miss", bus.vga_miss, e_vga_miss);
      chk("gl_rvalid", bus.gl_rvalid, e_gl_rvalid);
      chk("gl_rdata", bus.gl_rdata, e_gl_rdata);
      chk("fill_busy", fill_busy, m_busy);
      chk("fill_done", fill_done, m_done);
      chk("one_rvalid", int'(bus.vga_valid) + int'(bus.gl_rvalid) <= 1, 1);
      // advance one clock
      e_vga_valid = vga_win;
      e_vga_data  = vga_win ? Color'(sh_rd(va)) : '0;
      e_gl_rvalid = gl_win && !bus.gl_we;
      e_gl_rdata  = (gl_win && !bus.gl_we) ? Color'(sh_rd(ga)) : '0;
      e_vga_miss  = bus.vga_req && gl_win;
      if (ew != 0) shadow[ea] = Color'(ed);
      if (fill_win) m_ptr++;
      m_wait = (bus.gl_req && !gl_win) ? ((m_wait < MAX_W) ? m_wait + 1 : MAX_W) : 0;
      if (m_done) m_done = 0;
      else if (m_busy) begin
        if (m_ptr == FB_PIXELS) begin m_busy = 0; m_done = 1; end
      end else if (fill_start) begin
        m_busy = 1; m_ptr = 0; m_col = fill_color;
      end
      model_gnt = gl_win;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.vga_req = 0; bus.vga_addr = '0;
    bus.gl_req = 0; bus.gl_we = 0; bus.gl_addr = '0; bus.gl_wdata = '0;
    fill_start = 0; fill_color = '0;
  endtask

  function automatic FbAddr rnd_addr(input bit allow_oor);
    int r;
    r = $urandom_range(15);
    if (allow_oor && r == 0) return FbAddr'(FB_PIXELS + $urandom_range(200));
    if (r == 1) return FbAddr'(FB_PIXELS - 1);
    if (r < 6) return FbAddr'($urandom_range(FB_PIXELS - 1));
    return FbAddr'($urandom_range(63));
  endfunction

  task automatic rand_traffic(input int n, input bit alt_vga, input int gl_pct, input int fs_pct);
    for (int i = 0; i < n; i++) begin
      bus.vga_req  = alt_vga ? (i % 2 == 0) : ($urandom_range(1) == 1);
      bus.vga_addr = rnd_addr(0);
      if (!bus.gl_req || model_gnt) begin
        bus.gl_req   = $urandom_range(99) < gl_pct;
        bus.gl_we    = $urandom_range(1) == 1;
        bus.gl_addr  = rnd_addr(1);
        bus.gl_wdata = Color'($urandom);
      end
      fill_start = $urandom_range(99) < fs_pct;
      fill_color = Color'($urandom);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic gl_read_check(input int a, input int want, input string name);
    bus.gl_req = 1; bus.gl_we = 0; bus.gl_addr = FbAddr'(a);
    @(negedge clock);
    chk({name, "_gnt"}, bus.gl_gnt, 1);
    tick();
    bus.gl_req = 0;
    @(negedge clock);
    chk({name, "_rvalid"}, bus.gl_rvalid, 1);
    chk({name, "_rdata"}, bus.gl_rdata, want);
    tick();
  endtask

  initial begin
    int first_gnt, busy_cnt, done_cnt, done_at;
    reset = 1;
    idle_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_vga_valid", bus.vga_valid, 0);
    chk("rst_vga_miss", bus.vga_miss, 0);
    chk("rst_gl_rvalid", bus.gl_rvalid, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_gl_gnt", bus.gl_gnt, 0);
    chk("rst_ram_we", ram_we, 0);
    tick();
    reset = 0;
    tick();

    // idle RAM write then read of 38420
    bus.gl_req = 1; bus.gl_we = 1; bus.gl_addr = FbAddr'(38420); bus.gl_wdata = 3'b100;
    @(negedge clock);
    chk("wr_gnt", bus.gl_gnt, 1);
    chk("wr_ram_we", ram_we, 1);
    tick();
    bus.gl_req = 0;
    tick();
    gl_read_check(38420, 4, "rd38420");

    // starvation guard against continuous scanout
    bus.vga_req = 1; bus.vga_addr = FbAddr'(38420);
    bus.gl_req = 1; bus.gl_we = 0; bus.gl_addr = FbAddr'(5);
    first_gnt = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (bus.gl_gnt && first_gnt < 0) first_gnt = c;
      chk("stv_miss", bus.vga_miss, c == 9);
      if (c >= 1) chk("stv_vga_valid", bus.vga_valid, c != 9);
      tick();
      if (first_gnt >= 0) bus.gl_req = 0;
    end
    chk("stv_gnt_cycle", first_gnt, MAX_W);
    idle_inputs();
    tick();

    // out-of-range access; addr 0 holds a colour that aliasing would leak
    bus.gl_req = 1; bus.gl_we = 1; bus.gl_addr = '0; bus.gl_wdata = 3'b101;
    tick();
    bus.gl_addr = FbAddr'(FB_PIXELS); bus.gl_wdata = 3'b010;
    @(negedge clock);
    chk("oor_wr_gnt", bus.gl_gnt, 1);
    chk("oor_wr_we", ram_we, 0);
    tick();
    bus.gl_req = 0;
    tick();
    gl_read_check(FB_PIXELS, 0, "oor_rd");
    gl_read_check(0, 5, "alias_rd");

    rand_traffic(1500, 0, 40, 0);

    // fill start coinciding with a game-logic write, then fill under traffic
    bus.gl_req = 1; bus.gl_we = 1; bus.gl_addr = FbAddr'(7); bus.gl_wdata = 3'b011;
    fill_start = 1; fill_color = 3'b110;
    @(negedge clock);
    chk("sim_gnt", bus.gl_gnt, 1);
    tick();
    idle_inputs();
    @(negedge clock);
    chk("sim_fill_busy", fill_busy, 1);
    tick();
    rand_traffic(3000, 1, 10, 5);
    rand_traffic(1000, 0, 30, 5);

    // reset mid-fill
    @(negedge clock);
    chk("pre_rst_busy", fill_busy, 1);
    tick();
    reset = 1;
    #1;
    chk("rst_mid_busy", fill_busy, 0);
    chk("rst_mid_done", fill_done, 0);
    chk("rst_mid_gl_rvalid", bus.gl_rvalid, 0);
    chk("rst_mid_vga_valid", bus.vga_valid, 0);
    tick();
    tick();
    reset = 0;
    repeat (5) tick();

    // uncontested full fill with colour 7
    fill_start = 1; fill_color = 3'b111;
    tick();
    fill_start = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int n = 0; n < FB_PIXELS + 10; n++) begin
      @(negedge clock);
      if (n == 0) begin
        chk("fill_first_addr", ram_address, 0);
        chk("fill_first_we", ram_we, 1);
        chk("fill_first_wdata", ram_wdata, 7);
      end
      busy_cnt += int'(fill_busy);
      if (fill_done) begin
        done_cnt++;
        done_at = n;
      end
      tick();
    end
    chk("fill_busy_cycles", busy_cnt, FB_PIXELS);
    chk("fill_done_pulses", done_cnt, 1);
    chk("fill_done_cycle", done_at, FB_PIXELS);
    gl_read_check(0, 7, "fill_rd0");
    gl_read_check(FB_PIXELS - 1, 7, "fill_rd_last");
    gl_read_check(1000, 7, "fill_rd1000");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Shares the single-port 320x240x3 framebuffer RAM between three requesters: the VGA scanout reader, the game-logic port (read/write), and a built-in fill engine that clears or paints the whole screen. Scanout has priority; a starvation guard bounds game-logic wait. The fill engine runs only on otherwise idle RAM cycles. The block sits between the game logic, the VGA timing block and the RAM.

Parameters:
FB_WIDTH, 320, pixels per line
FB_HEIGHT, 240, lines
MAX_GL_WAIT, 8, cycles a pending game-logic request may lose to VGA before it overrides VGA for one cycle

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
vga_req  in  1  scanout read request this cycle
vga_addr  in  19  scanout pixel address
vga_valid  out  1  vga_data valid (one cycle after granted vga_req)
vga_data  out  3  scanout pixel colour
vga_miss  out  1  pulse: vga_req of previous cycle was pre-empted
gl_req  in  1  game-logic request; held until gl_gnt
gl_we  in  1  1 = write, 0 = read
gl_addr  in  19  game-logic address (320*y + x)
gl_wdata  in  3  write colour
gl_gnt  out  1  pulse in the cycle gl_* drives the RAM
gl_rvalid  out  1  gl_rdata valid (one cycle after a read grant)
gl_rdata  out  3  read colour
fill_start  in  1  pulse: start full-screen fill
fill_color  in  3  colour to fill; latched at start
fill_busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse after the last pixel is written
ram_address  out  19  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  3  RAM write data
ram_rdata  in  3  RAM read data, one-cycle synchronous latency

Behaviour:
- Reset values: every registered output 0; fill state IDLE; fill address, wait counter and latched colour 0. Combinational outputs (gl_gnt, ram_*) are 0 when nothing is granted.
- Per-cycle owner, decided combinationally:
  - OWN_GL if gl_req and wait_cnt == MAX_GL_WAIT (override).
  - Otherwise OWN_VGA if vga_req.
  - Otherwise OWN_GL if gl_req.
  - Otherwise OWN_FILL if fill state FILL.
  - Otherwise OWN_NONE.
- ram_address, ram_we and ram_wdata come from a mux on owner. VGA reads have ram_we = 0. In OWN_NONE, ram_address = 0 and ram_we = 0.
- gl_gnt = (owner == OWN_GL), in the same cycle, so the minimum grant latency is 0.
- wait_cnt:
  - increments while gl_req and not gl_gnt, saturating at MAX_GL_WAIT;
  - clears on gl_gnt or when gl_req is low.
- Read latency: vga_valid, vga_data, gl_rvalid and gl_rdata are registered one cycle after their grant, with data = ram_rdata. At most one of vga_valid / gl_rvalid is high in any cycle.
- vga_miss is registered 1 when vga_req was high and the owner was OWN_GL (override); vga_valid stays 0 that cycle.
- Out-of-range gl_addr (>= FB_WIDTH*FB_HEIGHT):
  - still granted;
  - ram_we is forced to 0 for writes;
  - a read returns gl_rdata = 0 with gl_rvalid = 1.
- Fill engine FSM, states IDLE, FILL, DONE:
  - IDLE to FILL on fill_start: latch fill_color, set fill_addr = 0, fill_busy = 1.
  - FILL: on each OWN_FILL cycle, write fill_color at fill_addr, then fill_addr++. After writing address FB_WIDTH*FB_HEIGHT-1, go to DONE.
  - DONE: fill_done = 1 for one cycle, fill_busy = 0, return to IDLE.
  - fill_start while busy is ignored.
  - Fill never pre-empts VGA or game logic.
  - A fill with no competing traffic takes exactly 76800 cycles from start to the DONE cycle.
- Simultaneous events:
  - fill_start in the same cycle as a game-logic request: the game logic is granted; the fill starts next cycle.
  - Game-logic writes during a fill are honoured in order, and the fill may later overwrite them.
- Reset mid-operation: the fill aborts with no fill_done, pending grants are dropped, and the read-valid pipeline clears.
- Widths: fill_addr is 19 bits; wait_cnt is $clog2(MAX_GL_WAIT+1) bits.

Decomposition:
- Package fb_types holds:
  - FB_WIDTH, FB_HEIGHT, FB_PIXELS, FB_ADDR_W = 19;
  - typedef Color (logic [2:0]);
  - enum ArbOwner {OWN_NONE, OWN_VGA, OWN_GL, OWN_FILL};
  - enum FillState {FILL_IDLE, FILL_RUN, FILL_DONE}.
- Sub-module fb_fill_engine: FSM plus address counter, with a grant input and a request/addr/data/busy/done output.

Test Plan:
- Idle RAM, gl write addr 38420 data 3'b100, then a read of 38420: gl_gnt in the same cycle as each request; gl_rvalid = 1 with gl_rdata = 3'b100 one cycle after the read grant.
- vga_req held high continuously, gl_req raised at cycle 0: gl_gnt at cycle MAX_GL_WAIT (8); vga_miss pulses at cycle 9; vga_valid is 0 at cycle 9 only.
- fill_start with colour 3'b111 and no other traffic: fill_busy = 1 for 76800 cycles; fill_done pulses once; a read of addresses 0, 76799 and 1000 returns 3'b111.
- Fill running, VGA requests every other cycle: fill completes in 153600 cycles; every VGA read is served (vga_valid after each request, no vga_miss).
- gl write to addr 76800 with data 3'b010: gl_gnt = 1 and ram_we = 0; a gl read at 76800 returns 0 with gl_rvalid = 1.
- Reset asserted midway through a fill: fill_busy = 0 immediately, fill_done never pulses; a new fill_start after reset runs from address 0.
